// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine: COLS_PER_CYCLE columns per clock,
// valid/ready on both sides, result held in the working register until taken.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int N  = 4 / COLS_PER_CYCLE;
  localparam int GW = 32 * COLS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $fatal(1, "mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds data stable while valid is high and ready is low.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [127:0]   work_q, work_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [GW-1:0]  grp_in, grp_out;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Row-0 product; other rows reuse it on a rotated column.
  function automatic logic [7:0] row0(input logic [7:0] a0, input logic [7:0] a1,
                                      input logic [7:0] a2, input logic [7:0] a3,
                                      input logic m);
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    x2[0] = xt(a0); x2[1] = xt(a1); x2[2] = xt(a2); x2[3] = xt(a3);
    x4[0] = xt(x2[0]); x4[1] = xt(x2[1]); x4[2] = xt(x2[2]); x4[3] = xt(x2[3]);
    x8[0] = xt(x4[0]); x8[1] = xt(x4[1]); x8[2] = xt(x4[2]); x8[3] = xt(x4[3]);
    if (m)
      return (x8[0] ^ x4[0] ^ x2[0]) ^ (x8[1] ^ x2[1] ^ a1) ^
             (x8[2] ^ x4[2] ^ a2) ^ (x8[3] ^ a3);
    else
      return x2[0] ^ x2[1] ^ a1 ^ a2 ^ a3;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic m);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {row0(a0, a1, a2, a3, m), row0(a1, a2, a3, a0, m),
            row0(a2, a3, a0, a1, m), row0(a3, a0, a1, a2, m)};
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = work_q;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    grp_in      = work_q[127 - GW * int'(cnt_q) -: GW];
    grp_out     = '0;
    for (int g = 0; g < COLS_PER_CYCLE; g++)
      grp_out[GW - 1 - 32 * g -: 32] = mix_col(grp_in[GW - 1 - 32 * g -: 32], mode_q);

    case (state_q)
      BUSY: begin
        work_d[127 - GW * int'(cnt_q) -: GW] = grp_out;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // Acceptance from IDLE or the DONE bypass both land here.
    if (in_valid && in_ready) begin
      work_d      = in_data;
      mode_d      = inv & INV_EN;
      cnt_d       = '0;
      state_d     = BUSY;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
